// File: rtl/neuron_mac_seq.sv
// Sequential 28-element Q8.8 dot product with bias and 16-bit saturation, weights from a BRAM.
// Optional feature: define NEURON_RELU_EN to clamp negative results to zero.
module neuron_mac_seq (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [15:0] BIAS,
    input  logic [15:0] X,
    input  logic        X_VALID,
    output logic        X_READY,
    output logic [4:0]  W_ADDR,
    output logic        W_EN,
    output logic        W_WE,
    input  logic [15:0] W_DO,
    output logic [15:0] Y,
    output logic        Y_VALID,
    output logic        BUSY
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StFin} state_e;

    localparam logic [4:0] LastIdx = 5'd27;

    state_e             state_q, state_d;
    logic [4:0]         count_q, count_d;
    logic signed [39:0] acc_q, acc_d;
    logic signed [15:0] x_q, w_q;
    logic               mac_pend_q;
    logic [15:0]        y_q, y_d;
    logic               y_valid_q, y_valid_d;
    logic               accept;
    logic signed [31:0] product;
    logic signed [31:0] acc_shift;
    logic [15:0]        sat_res;
    logic [15:0]        y_next;

    assign product   = x_q * w_q;
    assign acc_shift = acc_q[39:8];

    always_comb begin
        if (acc_shift > 32'sd32767) begin
            sat_res = 16'h7FFF;
        end else if (acc_shift < -32'sd32768) begin
            sat_res = 16'h8000;
        end else begin
            sat_res = acc_shift[15:0];
        end
    end

`ifdef NEURON_RELU_EN
    assign y_next = sat_res[15] ? 16'h0000 : sat_res;
`else
    assign y_next = sat_res;
`endif

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        y_d       = y_q;
        y_valid_d = 1'b0;
        accept    = 1'b0;
        // The product registered on the previous accept lands one edge later (also covers DRAIN).
        if (mac_pend_q) begin
            acc_d = acc_q + {{8{product[31]}}, product};
        end
        unique case (state_q)
            StIdle: begin
                if (START) begin
                    acc_d   = {{16{BIAS[15]}}, BIAS, 8'h00};
                    count_d = 5'd0;
                    state_d = StRun;
                end
            end
            StRun: begin
                accept = X_VALID;
                if (accept) begin
                    // Count holds at the last index so W_ADDR never passes 27.
                    if (count_q == LastIdx) begin
                        state_d = StDrain;
                    end else begin
                        count_d = count_q + 5'd1;
                    end
                end
            end
            StDrain: begin
                state_d = StFin;
            end
            StFin: begin
                y_d       = y_next;
                y_valid_d = 1'b1;
                state_d   = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            count_q    <= 5'd0;
            acc_q      <= 40'sd0;
            x_q        <= 16'sd0;
            w_q        <= 16'sd0;
            mac_pend_q <= 1'b0;
            y_q        <= 16'h0000;
            y_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            mac_pend_q <= accept;
            y_q        <= y_d;
            y_valid_q  <= y_valid_d;
            // BRAM data was read on the negedge inside the accept cycle; capture it with X
            // so a following accept cannot overwrite it before the MAC.
            if (accept) begin
                x_q <= X;
                w_q <= W_DO;
            end
        end
    end

    assign X_READY = (state_q == StRun);
    assign W_EN    = accept;
    assign W_ADDR  = count_q;
    assign W_WE    = 1'b0;
    assign Y       = y_q;
    assign Y_VALID = y_valid_q;
    assign BUSY    = (state_q != StIdle);

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed self-checking bench for neuron_mac_seq with a negedge-read weight BRAM model.
module tb_neuron_mac_seq;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [15:0] BIAS;
    logic [15:0] X;
    logic        X_VALID;
    logic        X_READY;
    logic [4:0]  W_ADDR;
    logic        W_EN;
    logic        W_WE;
    logic [15:0] W_DO = 16'h0000;
    logic [15:0] Y;
    logic        Y_VALID;
    logic        BUSY;

    logic [15:0] mem [28];
    logic [15:0] xv [28];
    int checks = 0;
    int failures = 0;

    neuron_mac_seq dut (
        .CLK(CLK), .RST(RST), .START(START), .BIAS(BIAS), .X(X), .X_VALID(X_VALID),
        .X_READY(X_READY), .W_ADDR(W_ADDR), .W_EN(W_EN), .W_WE(W_WE), .W_DO(W_DO),
        .Y(Y), .Y_VALID(Y_VALID), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (W_EN) W_DO <= mem[W_ADDR];

    task automatic fill(input logic [15:0] w, input logic [15:0] x);
        for (int i = 0; i < 28; i++) begin
            mem[i] = w;
            xv[i]  = x;
        end
    endtask

    // Drives one complete run; returns observed Y, Y_VALID latency after the last accept edge,
    // pulse count and the number of cycles where W_EN/W_ADDR disagreed with the accept history.
    task automatic run_dot(input logic [15:0] bias, input bit toggle, input bit poke_start,
                           output logic [15:0] y_obs, output int lat, output int pulses,
                           output int addr_errs);
        int k;
        int cyc;
        bit acc_now;
        logic [4:0] kk;
        k = 0; cyc = 0; addr_errs = 0; pulses = 0; lat = -1; y_obs = 16'hxxxx;
        START = 1'b1; BIAS = bias;
        @(posedge CLK); #1;
        START = 1'b0; BIAS = 16'h0000;
        while (k < 28 && cyc < 200) begin
            X_VALID = toggle ? (cyc % 2 == 0) : 1'b1;
            X = xv[k];
            START = poke_start && (k == 5);
            kk = 5'(k);
            @(negedge CLK);
            acc_now = X_VALID && X_READY;
            if (W_EN !== acc_now || W_ADDR !== kk) addr_errs++;
            @(posedge CLK); #1;
            cyc++;
            if (acc_now) k++;
        end
        X_VALID = 1'b0;
        START = poke_start;
        for (int n = 1; n <= 8; n++) begin
            @(posedge CLK); #1;
            START = 1'b0;
            if (Y_VALID === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat = n;
                    y_obs = Y;
                end
            end
        end
    endtask

    task automatic test_reset;
        RST = 1'b1; START = 1'b0; BIAS = 16'h0; X = 16'h0; X_VALID = 1'b0;
        repeat (2) @(posedge CLK);
        #1; RST = 1'b0;
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
        checks++; if (X_READY !== 1'b0) begin failures++; $display("FAIL reset_xready got=%b exp=0", X_READY); end
        checks++; if (W_EN !== 1'b0 || W_ADDR !== 5'd0) begin failures++; $display("FAIL reset_wport got en=%b addr=%0d exp en=0 addr=0", W_EN, W_ADDR); end
        checks++; if (Y !== 16'h0 || Y_VALID !== 1'b0) begin failures++; $display("FAIL reset_y got y=%h v=%b exp y=0000 v=0", Y, Y_VALID); end
        checks++; if (W_WE !== 1'b0) begin failures++; $display("FAIL reset_wwe got=%b exp=0", W_WE); end
    endtask

    task automatic test_basic;
        logic [15:0] y; int lat; int pulses; int errs;
        fill(16'h0100, 16'h0100);
        run_dot(16'h0000, 1'b0, 1'b0, y, lat, pulses, errs);
        checks++; if (y !== 16'h1C00) begin failures++; $display("FAIL basic_y got=%h exp=1c00", y); end
        checks++; if (lat != 2) begin failures++; $display("FAIL basic_latency got=%0d exp=2", lat); end
        checks++; if (pulses != 1) begin failures++; $display("FAIL basic_pulses got=%0d exp=1", pulses); end
        checks++; if (errs != 0) begin failures++; $display("FAIL basic_wport got=%0d errs exp=0", errs); end
        checks++; if (Y !== 16'h1C00 || BUSY !== 1'b0) begin failures++; $display("FAIL basic_hold got y=%h busy=%b exp y=1c00 busy=0", Y, BUSY); end
        checks++; if (W_ADDR > 5'd27) begin failures++; $display("FAIL basic_addr_max got=%0d exp<=27", W_ADDR); end
    endtask

    task automatic test_saturation;
        logic [15:0] y; int lat; int pulses; int errs;
        fill(16'h7FFF, 16'h7FFF);
        run_dot(16'h0000, 1'b0, 1'b0, y, lat, pulses, errs);
        checks++; if (y !== 16'h7FFF) begin failures++; $display("FAIL sat_pos got=%h exp=7fff", y); end
        fill(16'h8000, 16'h7FFF);
        run_dot(16'h0000, 1'b0, 1'b0, y, lat, pulses, errs);
`ifdef NEURON_RELU_EN
        checks++; if (y !== 16'h0000) begin failures++; $display("FAIL sat_neg got=%h exp=0000", y); end
`else
        checks++; if (y !== 16'h8000) begin failures++; $display("FAIL sat_neg got=%h exp=8000", y); end
`endif
    endtask

    task automatic test_negative;
        logic [15:0] y; int lat; int pulses; int errs;
        fill(16'hFF00, 16'h0100);
        run_dot(16'h0000, 1'b0, 1'b0, y, lat, pulses, errs);
`ifdef NEURON_RELU_EN
        checks++; if (y !== 16'h0000) begin failures++; $display("FAIL negative got=%h exp=0000", y); end
`else
        checks++; if (y !== 16'hE400) begin failures++; $display("FAIL negative got=%h exp=e400", y); end
`endif
    endtask

    task automatic test_mixed;
        logic [15:0] y; int lat; int pulses; int errs;
        // w[i] = i.0, x[k] = 1.0 for k<14 else 0, bias -0.5: 91.0 - 0.5 = 0x5A80
        for (int i = 0; i < 28; i++) begin
            mem[i] = 16'(i * 256);
            xv[i]  = (i < 14) ? 16'h0100 : 16'h0000;
        end
        run_dot(16'hFF80, 1'b0, 1'b0, y, lat, pulses, errs);
        checks++; if (y !== 16'h5A80) begin failures++; $display("FAIL mixed_y got=%h exp=5a80", y); end
    endtask

    task automatic test_toggle;
        logic [15:0] y; int lat; int pulses; int errs;
        fill(16'h0100, 16'h0100);
        run_dot(16'h0000, 1'b1, 1'b0, y, lat, pulses, errs);
        checks++; if (y !== 16'h1C00) begin failures++; $display("FAIL toggle_y got=%h exp=1c00", y); end
        checks++; if (errs != 0) begin failures++; $display("FAIL toggle_wport got=%0d errs exp=0", errs); end
        checks++; if (lat != 2) begin failures++; $display("FAIL toggle_latency got=%0d exp=2", lat); end
    endtask

    task automatic test_abort;
        logic [15:0] y; int lat; int pulses; int errs; int vp;
        fill(16'h0100, 16'h0100);
        START = 1'b1; BIAS = 16'h0;
        @(posedge CLK); #1;
        START = 1'b0; X_VALID = 1'b1; X = 16'h0100;
        repeat (10) @(posedge CLK);
        #1;
        RST = 1'b1; X_VALID = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        checks++; if (BUSY !== 1'b0 || X_READY !== 1'b0) begin failures++; $display("FAIL abort_idle got busy=%b xready=%b exp 0 0", BUSY, X_READY); end
        checks++; if (Y !== 16'h0 || W_ADDR !== 5'd0) begin failures++; $display("FAIL abort_clear got y=%h addr=%0d exp y=0000 addr=0", Y, W_ADDR); end
        vp = 0;
        repeat (6) begin
            @(posedge CLK); #1;
            if (Y_VALID !== 1'b0) vp++;
        end
        checks++; if (vp != 0) begin failures++; $display("FAIL abort_no_pulse got=%0d exp=0", vp); end
        RST = 1'b1; START = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0; START = 1'b0;
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL rst_over_start got busy=%b exp=0", BUSY); end
        run_dot(16'h0000, 1'b0, 1'b0, y, lat, pulses, errs);
        checks++; if (y !== 16'h1C00) begin failures++; $display("FAIL abort_rerun got=%h exp=1c00", y); end
    endtask

    task automatic test_start_ignored;
        logic [15:0] y; int lat; int pulses; int errs;
        fill(16'h0100, 16'h0100);
        run_dot(16'h0200, 1'b0, 1'b1, y, lat, pulses, errs);
        checks++; if (y !== 16'h1E00) begin failures++; $display("FAIL start_ignored_y got=%h exp=1e00", y); end
        checks++; if (pulses != 1 || lat != 2) begin failures++; $display("FAIL start_ignored_pulse got pulses=%0d lat=%0d exp 1 2", pulses, lat); end
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL start_ignored_idle got busy=%b exp=0", BUSY); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_saturation;
        test_negative;
        test_mixed;
        test_toggle;
        test_abort;
        test_start_ignored;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/neuron_mac_seq.md
NEURON_MAC_SEQ -- requirements
Module: neuron_mac_seq

Interface
REQ-001 SHALL have port CLK, input, 1, sole clock; all state updates on posedge CLK.
REQ-002 SHALL have port RST, input, 1, synchronous active-high reset.
REQ-003 SHALL have port START, input, 1, one-cycle request to begin a 28-element dot product.
REQ-004 SHALL have port BIAS, input, 16, signed Q8.8 bias, sampled on the START accept edge.
REQ-005 SHALL have port X, input, 16, signed Q8.8 activation element.
REQ-006 SHALL have port X_VALID, input, 1, X holds a valid element.
REQ-007 SHALL have port X_READY, output, 1, block accepts X this cycle.
REQ-008 SHALL have port W_ADDR, output, 5, weight BRAM address.
REQ-009 SHALL have port W_EN, output, 1, weight BRAM enable.
REQ-010 SHALL have port W_WE, output, 1, weight BRAM write enable, tied 0.
REQ-011 SHALL have port W_DO, input, 16, signed Q8.8 weight from BRAM, captured by the BRAM on negedge CLK.
REQ-012 SHALL have port Y, output, 16, signed Q8.8 neuron result.
REQ-013 SHALL have port Y_VALID, output, 1, one-cycle pulse marking Y valid.
REQ-014 SHALL have port BUSY, output, 1, high in any state other than IDLE.

Function
REQ-015 SHALL implement states IDLE, RUN, DRAIN, FIN.
REQ-016 IDLE: START=1 SHALL load acc = sign-extend(BIAS)<<8, set count=0, and enter RUN; START in any other state SHALL be ignored.
REQ-017 RUN: X_READY SHALL be 1; an accept (X_VALID & X_READY) SHALL drive W_EN=1 and W_ADDR=count in that cycle, register X, and increment count.
REQ-018 With no accept, W_EN SHALL be 0 and W_ADDR and count SHALL hold.
REQ-019 Edge after each accept: acc SHALL add signed 32-bit product X_reg*W_DO (Q16.16) into a 40-bit signed accumulator, with no intermediate saturation.
REQ-020 Accept with count=27 SHALL transition RUN->DRAIN; X_READY SHALL be 0 in DRAIN, FIN, IDLE.
REQ-021 DRAIN SHALL perform the final MAC and go to FIN unconditionally.
REQ-022 FIN SHALL register Y = saturate16(acc>>>8), pulse Y_VALID=1 for exactly one cycle, and return to IDLE.
REQ-023 Y_VALID SHALL rise 2 clocks after the accept edge of element 27; Y SHALL hold until the next FIN or reset.
REQ-024 Saturation SHALL clamp to 0x7FFF / 0x8000.
REQ-025 W_ADDR SHALL never exceed 27 and SHALL not wrap within a run.

Reset
REQ-026 RST=1 SHALL force IDLE, count=0, acc=0, Y=0, Y_VALID=0, X_READY=0, W_EN=0, W_ADDR=0, BUSY=0 at the next posedge, from any state.
REQ-027 Reset mid-run SHALL abort the run with no Y_VALID pulse; RST takes priority over a simultaneous START.

Configuration
REQ-028 Macro NEURON_RELU_EN defined: Y SHALL be 0x0000 whenever the saturated result is negative. Undefined: Y SHALL be the signed saturated result.

Verification
REQ-029 All W=0x0100, X=0x0100 x28, BIAS=0, X_VALID held high -> Y=0x1C00; Y_VALID 2 clocks after 28th accept.
REQ-030 All W=0x7FFF, X=0x7FFF x28 -> Y=0x7FFF (saturated).
REQ-031 All W=0xFF00, X=0x0100, BIAS=0 -> Y=0xE400 without NEURON_RELU_EN; Y=0x0000 with it.
REQ-032 Same stimulus as REQ-029 with X_VALID toggling every cycle -> Y=0x1C00; W_ADDR advances only on accepts; W_EN=0 on idle cycles.
REQ-033 RST after 10 accepts -> BUSY=0 next cycle and no Y_VALID pulse; a fresh run afterwards -> Y=0x1C00.
REQ-034 START pulsed in RUN and DRAIN -> ignored; BIAS=0x0200 on the original START -> Y=0x1E00.
